// File: rtl/eim_da_sequencer.sv
// rtl/eim_da_sequencer.sv - EIM multiplexed address/data port transaction sequencer
// Oversamples host strobes, issues single-beat system bus requests, drives read data back.
module eim_da_sequencer #(
  parameter int BUS_WIDTH  = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  eim_cs_n,
  input  logic                  eim_lba_n,
  input  logic                  eim_wr_n,
  input  logic                  eim_oe_n,
  output logic                  eim_wait_n,
  input  logic [BUS_WIDTH-1:0]  da_ro,
  output logic [BUS_WIDTH-1:0]  da_di,
  output logic                  da_t,
  output logic [ADDR_WIDTH-1:0] sys_addr,
  output logic                  sys_wren,
  output logic                  sys_rden,
  output logic [BUS_WIDTH-1:0]  sys_data_out,
  input  logic [BUS_WIDTH-1:0]  sys_data_in,
  input  logic                  sys_ack,
  output logic                  sys_timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, DIR, WR_REQ, RD_REQ, RD_DRIVE, DONE
  } state_t;

  logic [1:0]            cs_sync_q, lba_sync_q, wr_sync_q, oe_sync_q;
  logic [BUS_WIDTH-1:0]  da_s1_q, da_s2_q;
  logic                  cs, lba, wr, oe;
  logic [BUS_WIDTH-1:0]  da;

  state_t                state_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  timeout_hit;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [BUS_WIDTH-1:0]  dout_q, di_q;
  logic                  t_q, wait_q, wren_q, rden_q, to_q;

  // DA data takes the same two-stage path as the strobes so both line up at the FSM.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cs_sync_q  <= 2'b11;
      lba_sync_q <= 2'b11;
      wr_sync_q  <= 2'b11;
      oe_sync_q  <= 2'b11;
      da_s1_q    <= '0;
      da_s2_q    <= '0;
    end else begin
      cs_sync_q  <= {cs_sync_q[0], eim_cs_n};
      lba_sync_q <= {lba_sync_q[0], eim_lba_n};
      wr_sync_q  <= {wr_sync_q[0], eim_wr_n};
      oe_sync_q  <= {oe_sync_q[0], eim_oe_n};
      da_s1_q    <= da_ro;
      da_s2_q    <= da_s1_q;
    end
  end

  assign cs  = cs_sync_q[1];
  assign lba = lba_sync_q[1];
  assign wr  = wr_sync_q[1];
  assign oe  = oe_sync_q[1];
  assign da  = da_s2_q;

  always_comb begin
    cnt_d = '0;
    if (state_q == WR_REQ || state_q == RD_REQ) cnt_d = cnt_q + 1'b1;
  end

  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      dout_q  <= '0;
      di_q    <= '0;
      t_q     <= 1'b1;
      wait_q  <= 1'b1;
      wren_q  <= 1'b0;
      rden_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= 1'b0;
      // Driver enabled only while the host still holds cs and oe low in RD_DRIVE.
      t_q   <= !(state_q == RD_DRIVE && !cs && !oe);
      case (state_q)
        IDLE: begin
          if (!cs && !lba) begin
            addr_q  <= da[ADDR_WIDTH-1:0];
            state_q <= ADDR;
          end
        end
        ADDR: begin
          if (cs)       state_q <= IDLE;
          else if (lba) state_q <= DIR;
        end
        DIR: begin
          if (cs) begin
            state_q <= IDLE;
          end else if (!wr) begin
            dout_q  <= da;
            wren_q  <= 1'b1;
            wait_q  <= 1'b0;
            state_q <= WR_REQ;
          end else if (!oe) begin
            rden_q  <= 1'b1;
            wait_q  <= 1'b0;
            state_q <= RD_REQ;
          end
        end
        WR_REQ: begin
          if (sys_ack || timeout_hit) begin
            wren_q  <= 1'b0;
            wait_q  <= 1'b1;
            to_q    <= !sys_ack;
            state_q <= DONE;
          end
        end
        RD_REQ: begin
          // A real ack in the timeout cycle still wins and supplies the data.
          if (sys_ack || timeout_hit) begin
            di_q    <= sys_ack ? sys_data_in : {BUS_WIDTH{1'b1}};
            rden_q  <= 1'b0;
            wait_q  <= 1'b1;
            to_q    <= !sys_ack;
            state_q <= cs ? IDLE : RD_DRIVE;
          end
        end
        RD_DRIVE: begin
          if (cs) state_q <= IDLE;
        end
        DONE: begin
          if (cs) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign eim_wait_n   = wait_q;
  assign da_di        = di_q;
  assign da_t         = t_q;
  assign sys_addr     = addr_q;
  assign sys_wren     = wren_q;
  assign sys_rden     = rden_q;
  assign sys_data_out = dout_q;
  assign sys_timeout  = to_q;

endmodule

// File: tb/tb_eim_da_sequencer.sv
// tb/tb_eim_da_sequencer.sv - self-checking bench for eim_da_sequencer
// Table of directed host transactions, then random transactions against a transaction-level model.
module tb_eim_da_sequencer;

  localparam int BW = 16;
  localparam int AW = 16;
  localparam int TO = 8;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic          eim_cs_n, eim_lba_n, eim_wr_n, eim_oe_n;
  logic          eim_wait_n;
  logic [BW-1:0] da_ro, da_di, sys_data_out, sys_data_in;
  logic          da_t, sys_wren, sys_rden, sys_ack, sys_timeout;
  logic [AW-1:0] sys_addr;

  eim_da_sequencer #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .eim_cs_n(eim_cs_n), .eim_lba_n(eim_lba_n), .eim_wr_n(eim_wr_n), .eim_oe_n(eim_oe_n),
    .eim_wait_n(eim_wait_n), .da_ro(da_ro), .da_di(da_di), .da_t(da_t),
    .sys_addr(sys_addr), .sys_wren(sys_wren), .sys_rden(sys_rden),
    .sys_data_out(sys_data_out), .sys_data_in(sys_data_in),
    .sys_ack(sys_ack), .sys_timeout(sys_timeout)
  );

  always #5 sys_clk = ~sys_clk;

  // abort: 0 none, 1 cs rises while in DIR, 2 cs rises during request, 3 reset in RD_DRIVE
  typedef struct {
    bit            wr;
    logic [15:0]   addr, data, rdata;
    int            dly, abort;
    logic [15:0]   e_addr, e_dout, e_di;
    int            e_req, e_to;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;
  int wren_n, rden_n, wlow_n, to_n, tlow_n, req_k, ack_dly;
  logic [BW-1:0] ack_data;
  logic [BW-1:0] mdl_dout;

  task automatic check(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s %s: got 0x%0h expected 0x%0h", tag, what, act, exp);
    end
  endtask

  // One sys_clk cycle: sample outputs at the falling edge and play the bus slave.
  task automatic step();
    @(negedge sys_clk);
    wren_n += int'(sys_wren);
    rden_n += int'(sys_rden);
    wlow_n += int'(!eim_wait_n);
    to_n   += int'(sys_timeout);
    tlow_n += int'(!da_t);
    sys_ack     = 1'b0;
    sys_data_in = BW'($urandom);
    if (sys_wren || sys_rden) begin
      if (req_k == ack_dly) begin
        sys_ack     = 1'b1;
        sys_data_in = ack_data;
      end
      req_k++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      eim_cs_n = 1'b1; eim_lba_n = 1'b1; eim_wr_n = 1'b1; eim_oe_n = 1'b1;
      da_ro = BW'($urandom);
      sys_ack = 1'($urandom);
      sys_data_in = BW'($urandom);
    end
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    bit seen;
    wren_n = 0; rden_n = 0; wlow_n = 0; to_n = 0; tlow_n = 0; req_k = 0;
    ack_dly = v.dly; ack_data = v.rdata;
    step();
    eim_cs_n = 1'b0; eim_lba_n = 1'b0; da_ro = v.addr;
    repeat (3) step();
    step();
    eim_lba_n = 1'b1;
    da_ro = v.wr ? v.data : BW'($urandom);
    if (v.abort == 1) begin
      repeat (3) step();
      eim_cs_n = 1'b1;
      if (v.wr) eim_wr_n = 1'b0; else eim_oe_n = 1'b0;
      repeat (6) step();
    end else begin
      if (v.wr) eim_wr_n = 1'b0; else eim_oe_n = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 60; c++) begin
        step();
        if (sys_wren || sys_rden) begin
          seen = 1'b1;
          if (v.abort == 2) begin
            eim_cs_n = 1'b1; eim_wr_n = 1'b1; eim_oe_n = 1'b1;
          end
        end else if (seen) begin
          break;
        end
      end
      check(tag, "request_completed", 32'(seen && !(sys_wren || sys_rden)), 32'd1);
      check(tag, "wait_released", 32'(eim_wait_n), 32'd1);
      if (!v.wr) check(tag, "da_di", 32'(da_di), 32'(v.e_di));
      if (!v.wr && (v.abort == 0 || v.abort == 3)) begin
        check(tag, "da_t_at_wait_rise", 32'(da_t), 32'd1);
        step();
        check(tag, "da_t_drive", 32'(da_t), 32'd0);
      end
    end
    if (v.abort == 3) begin
      #1 sys_rst = 1'b1;
      #1;
      check(tag, "rst_da_t", 32'(da_t), 32'd1);
      check(tag, "rst_wait_n", 32'(eim_wait_n), 32'd1);
      check(tag, "rst_da_di", 32'(da_di), 32'd0);
      check(tag, "rst_rden", 32'(sys_rden), 32'd0);
      step();
      eim_cs_n = 1'b1; eim_wr_n = 1'b1; eim_oe_n = 1'b1;
      step();
      sys_rst = 1'b0;
    end else if (v.abort != 1) begin
      step(); step();
      eim_cs_n = 1'b1; eim_wr_n = 1'b1; eim_oe_n = 1'b1;
      repeat (3) step();
      check(tag, "da_t_after_cs_rise", 32'(da_t), 32'd1);
    end
    eim_cs_n = 1'b1; eim_wr_n = 1'b1; eim_oe_n = 1'b1; eim_lba_n = 1'b1;
    repeat (3) step();
    check(tag, "wren_cycles", 32'(wren_n), 32'(v.wr ? v.e_req : 0));
    check(tag, "rden_cycles", 32'(rden_n), 32'(v.wr ? 0 : v.e_req));
    check(tag, "wait_low_cycles", 32'(wlow_n), 32'(v.e_req));
    check(tag, "timeout_pulses", 32'(to_n), 32'(v.e_to));
    if (v.wr || v.abort == 1 || v.abort == 2) check(tag, "da_t_low_cycles", 32'(tlow_n), 32'd0);
    check(tag, "sys_addr", 32'(sys_addr), 32'(v.e_addr));
    check(tag, "sys_data_out", 32'(sys_data_out), 32'(v.e_dout));
    check(tag, "idle_wait_n", 32'(eim_wait_n), 32'd1);
  endtask

  function automatic vec_t mk(input bit wr, input logic [15:0] addr, input logic [15:0] data,
                              input logic [15:0] rdata, input int dly, input int abort,
                              input logic [15:0] ea, input logic [15:0] ed, input logic [15:0] ei,
                              input int er, input int eto);
    vec_t v;
    v.wr = wr; v.addr = addr; v.data = data; v.rdata = rdata; v.dly = dly; v.abort = abort;
    v.e_addr = ea; v.e_dout = ed; v.e_di = ei; v.e_req = er; v.e_to = eto;
    return v;
  endfunction

  // Transaction-level expectation: a request lasts until ack or TO cycles, whichever first.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    bit acked;
    r = v;
    acked = (v.dly < TO);
    r.e_addr = v.addr;
    if (v.abort == 1) begin
      r.e_req = 0;
      r.e_to  = 0;
    end else begin
      r.e_req = acked ? v.dly + 1 : TO;
      r.e_to  = acked ? 0 : 1;
      if (v.wr) mdl_dout = v.data;
    end
    r.e_dout = mdl_dout;
    r.e_di   = acked ? v.rdata : 16'hFFFF;
    return r;
  endfunction

  vec_t tbl[10];
  vec_t rv;

  initial begin
    tbl[0] = mk(1, 16'h0012, 16'hBEEF, 16'h0000,   2, 0, 16'h0012, 16'hBEEF, 16'h0000, 3, 0);
    tbl[1] = mk(0, 16'h0034, 16'h0000, 16'hCAFE,   5, 0, 16'h0034, 16'hBEEF, 16'hCAFE, 6, 0);
    tbl[2] = mk(0, 16'h0056, 16'h0000, 16'h9999, 100, 0, 16'h0056, 16'hBEEF, 16'hFFFF, 8, 1);
    tbl[3] = mk(1, 16'h0078, 16'h5A5A, 16'h0000, 100, 0, 16'h0078, 16'h5A5A, 16'h0000, 8, 1);
    tbl[4] = mk(1, 16'h009A, 16'h1111, 16'h0000,   2, 1, 16'h009A, 16'h5A5A, 16'h0000, 0, 0);
    tbl[5] = mk(0, 16'h00BC, 16'h0000, 16'h2222,   6, 2, 16'h00BC, 16'h5A5A, 16'h2222, 7, 0);
    tbl[6] = mk(0, 16'h00DE, 16'h0000, 16'h1234,   7, 0, 16'h00DE, 16'h5A5A, 16'h1234, 8, 0);
    tbl[7] = mk(1, 16'hFFFF, 16'h0000, 16'h0000,   0, 0, 16'hFFFF, 16'h0000, 16'h0000, 1, 0);
    tbl[8] = mk(0, 16'h0101, 16'h0000, 16'h3333,   1, 3, 16'h0000, 16'h0000, 16'h3333, 2, 0);
    tbl[9] = mk(1, 16'h0042, 16'hA5A5, 16'h0000,   3, 0, 16'h0042, 16'hA5A5, 16'h0000, 4, 0);

    eim_cs_n = 1'b1; eim_lba_n = 1'b1; eim_wr_n = 1'b1; eim_oe_n = 1'b1;
    da_ro = '0; sys_ack = 1'b0; sys_data_in = '0;
    sys_rst = 1'b0;
    #1 sys_rst = 1'b1;
    #2;
    check("reset", "da_t", 32'(da_t), 32'd1);
    check("reset", "da_di", 32'(da_di), 32'd0);
    check("reset", "wait_n", 32'(eim_wait_n), 32'd1);
    check("reset", "sys_addr", 32'(sys_addr), 32'd0);
    check("reset", "sys_data_out", 32'(sys_data_out), 32'd0);
    check("reset", "sys_wren", 32'(sys_wren), 32'd0);
    check("reset", "sys_rden", 32'(sys_rden), 32'd0);
    check("reset", "sys_timeout", 32'(sys_timeout), 32'd0);
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    idle(4);

    for (int i = 0; i < 10; i++) begin
      run_txn(tbl[i], $sformatf("tbl%0d", i));
      idle(4);
    end

    mdl_dout = tbl[9].e_dout;
    for (int i = 0; i < 40; i++) begin
      int r;
      rv.wr    = 1'($urandom);
      rv.addr  = 16'($urandom);
      rv.data  = 16'($urandom);
      rv.rdata = 16'($urandom);
      r = int'($urandom_range(0, 7));
      if (r == 0)      rv.dly = TO + 5;
      else if (r == 1) rv.dly = TO - 1;
      else             rv.dly = int'($urandom_range(0, TO - 2));
      r = int'($urandom_range(0, 9));
      if (r == 0)                     rv.abort = 1;
      else if (r == 1 && rv.dly >= 3) rv.abort = 2;
      else                            rv.abort = 0;
      rv = model(rv);
      run_txn(rv, $sformatf("rnd%0d", i));
      idle(int'($urandom_range(3, 6)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
